// File: rtl/count_reporter.sv
// Watches two 64-bit counters, snapshots every value change with its source, buffers the
// snapshots in a small FIFO and streams each one out as a low/high pair of 32-bit beats.
module count_reporter #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [63:0]              Count0,
    input  logic [63:0]              Count1,
    input  logic                     Out_Ready,
    output logic                     Out_Valid,
    output logic [31:0]              Out_Data,
    output logic                     Out_Last,
    output logic                     Out_Src,
    output logic [$clog2(DEPTH):0]   Fifo_Level,
    output logic [DROP_W-1:0]        Drop_Cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [63:0]       prev0_r, prev1_r;
    logic [63:0]       val0_r, val1_r;
    logic              pend0_r, pend1_r;
    logic              last_grant_r;
    logic [63:0]       mem_val_r [DEPTH];
    logic              mem_src_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              phase_r;
    logic [DROP_W-1:0] drop_r;

    logic              chg0_s, chg1_s;
    logic              full_s, empty_s;
    logic              beat_s, pop_s, can_push_s;
    logic              grant0_s, grant1_s, push_s;
    logic [63:0]       push_val_s;
    logic [1:0]        drop_inc_s;
    logic [DROP_W:0]   drop_sum_s;
    logic [DROP_W-1:0] drop_next_s;
    logic [LW-1:0]     level_next_s;
    logic [63:0]       head_val_s;
    logic              head_src_s;

    assign chg0_s     = (Count0 != prev0_r);
    assign chg1_s     = (Count1 != prev1_r);
    assign full_s     = (level_r == LW'(DEPTH));
    assign empty_s    = (level_r == {LW{1'b0}});
    assign beat_s     = !empty_s && Out_Ready;
    assign pop_s      = beat_s && phase_r;
    // A slot freed by this edge's pop can be refilled on the same edge.
    assign can_push_s = !full_s || pop_s;
    assign head_val_s = mem_val_r[rd_ptr_r];
    assign head_src_s = mem_src_r[rd_ptr_r];

    // Arbitration between the two pending snapshots; ties alternate away from the last winner.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({can_push_s, pend0_r, pend1_r})
            3'b111: begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end
            3'b110:  grant0_s = 1'b1;
            3'b101:  grant1_s = 1'b1;
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
        push_s     = grant0_s || grant1_s;
        push_val_s = grant1_s ? val1_r : val0_r;
    end

    // Coalesce accounting: an overwritten, ungranted pending value is a lost snapshot.
    always_comb begin
        drop_inc_s = {1'b0, chg0_s && pend0_r && !grant0_s}
                   + {1'b0, chg1_s && pend1_r && !grant1_s};
        drop_sum_s = {1'b0, drop_r} + (DROP_W+1)'(drop_inc_s);
        if (drop_sum_s[DROP_W]) begin
            drop_next_s = {DROP_W{1'b1}};
        end else begin
            drop_next_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Previous-value history used for change detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prev0_r <= 64'd0;
            prev1_r <= 64'd0;
        end else begin
            prev0_r <= Count0;
            prev1_r <= Count1;
        end
    end

    // Pending snapshot per source, round-robin memory and the drop counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend0_r      <= 1'b0;
            pend1_r      <= 1'b0;
            val0_r       <= 64'd0;
            val1_r       <= 64'd0;
            last_grant_r <= 1'b1;
            drop_r       <= {DROP_W{1'b0}};
        end else begin
            if (chg0_s) begin
                pend0_r <= 1'b1;
                val0_r  <= Count0;
            end else if (grant0_s) begin
                pend0_r <= 1'b0;
            end
            if (chg1_s) begin
                pend1_r <= 1'b1;
                val1_r  <= Count1;
            end else if (grant1_s) begin
                pend1_r <= 1'b0;
            end
            if (push_s) begin
                last_grant_r <= grant1_s;
            end
            drop_r <= drop_next_s;
        end
    end

    // Snapshot FIFO storage, pointers, occupancy and beat phase.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_val_r[i] <= 64'd0;
                mem_src_r[i] <= 1'b0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            phase_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_val_r[wr_ptr_r] <= push_val_s;
                mem_src_r[wr_ptr_r] <= grant1_s;
                wr_ptr_r            <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (beat_s) begin
                phase_r <= !phase_r;
            end
            level_r <= level_next_s;
        end
    end

    // Beat presentation from the FIFO head; zeros while nothing is buffered.
    always_comb begin
        Out_Valid = !empty_s;
        Out_Data  = 32'd0;
        Out_Last  = 1'b0;
        Out_Src   = 1'b0;
        if (!empty_s) begin
            Out_Data = phase_r ? head_val_s[63:32] : head_val_s[31:0];
            Out_Last = phase_r;
            Out_Src  = head_src_s;
        end else begin
            Out_Data = 32'd0;
            Out_Last = 1'b0;
            Out_Src  = 1'b0;
        end
    end

    assign Fifo_Level = level_r;
    assign Drop_Cnt   = drop_r;

endmodule
